// File: rtl/instr_fetch_unit_if.sv
// Issue/load bus between the instruction fetch unit and its controller and datapath.
// Signal directions in the i_/o_ prefixes are seen from the fetch unit.
interface instr_fetch_unit_if #(
  parameter int ADDR_W = 6
);
  logic              i_start;
  logic              i_load_en;
  logic [ADDR_W-1:0] i_load_addr;
  logic [31:0]       i_load_data;
  logic              i_br_zero;
  logic [31:0]       o_instrword;
  logic              o_newinstr;
  logic [ADDR_W-1:0] o_pc;
  logic              o_busy;
  logic              o_halted;
  logic [15:0]       o_retired;

  modport master (
    output i_start, i_load_en, i_load_addr, i_load_data, i_br_zero,
    input  o_instrword, o_newinstr, o_pc, o_busy, o_halted, o_retired
  );

  modport slave (
    input  i_start, i_load_en, i_load_addr, i_load_data, i_br_zero,
    output o_instrword, o_newinstr, o_pc, o_busy, o_halted, o_retired
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction-issue front end: PC, loadable instruction memory, issue pulse to the
// multi-cycle datapath, internal resolution of j/beq, and stop on the halt word.
module instr_fetch_unit #(
  parameter int          ADDR_W      = 6,
  parameter int          DEPTH       = 2**ADDR_W,
  parameter int          EXEC_CYCLES = 5,
  parameter logic [31:0] HALT_WORD   = 32'hFFFF_FFFF
) (
  input logic               clk,
  input logic               rst,
  instr_fetch_unit_if.slave bus
);

  localparam int          CNT_W    = $clog2(EXEC_CYCLES + 1);
  localparam logic [5:0]  OP_J     = 6'd2;
  localparam logic [5:0]  OP_BEQ   = 6'd4;
  localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_ISSUE = 3'd2,
    S_EXEC  = 3'd3,
    S_NEXT  = 3'd4,
    S_HALT  = 3'd5
  } state_t;

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [31:0]       r_instrword;
  logic              r_newinstr;
  logic              r_busy;
  logic              r_halted;
  logic [15:0]       r_retired;
  logic [CNT_W-1:0]  r_cnt;
  logic [31:0]       r_mem [DEPTH];

  logic [31:0]       w_fetch;
  logic              w_fetch_halt;
  logic              w_fetch_ctrl;
  logic              w_is_j;
  logic              w_is_beq;
  logic              w_taken;
  logic              w_load_ok;
  logic              w_seq_end;
  logic [ADDR_W-1:0] w_pc_next;
  logic [15:0]       w_ret_next;

  assign w_fetch      = r_mem[r_pc];
  assign w_fetch_halt = (w_fetch == HALT_WORD);
  assign w_fetch_ctrl = (w_fetch[31:26] == OP_J) || (w_fetch[31:26] == OP_BEQ);

  // NEXT decodes the latched word; br_zero belongs to that word.
  assign w_is_j    = (r_instrword[31:26] == OP_J);
  assign w_is_beq  = (r_instrword[31:26] == OP_BEQ);
  assign w_taken   = w_is_beq && bus.i_br_zero;
  assign w_load_ok = bus.i_load_en && ((r_state == S_IDLE) || (r_state == S_HALT));

  // Next-PC selection, end-of-memory detection and saturating retire count.
  always_comb begin
    w_pc_next  = r_pc + ADDR_W'(1);
    w_seq_end  = 1'b0;
    w_ret_next = r_retired;
    if (w_is_j) begin
      w_pc_next = r_instrword[ADDR_W-1:0];
    end else if (w_taken) begin
      // Low ADDR_W bits of the sign-extended offset give the modulo-DEPTH result.
      w_pc_next = r_pc + ADDR_W'(1) + r_instrword[ADDR_W-1:0];
    end else begin
      w_seq_end = (r_pc == PC_LAST);
    end
    if (r_retired != 16'hFFFF) begin
      w_ret_next = r_retired + 16'd1;
    end else begin
      w_ret_next = r_retired;
    end
  end

  // Instruction memory write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_load_ok) begin
      r_mem[bus.i_load_addr] <= bus.i_load_data;
    end
  end

  // Issue sequencer with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_pc        <= '0;
      r_instrword <= 32'd0;
      r_newinstr  <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_retired   <= 16'd0;
      r_cnt       <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_HALT: begin
          if (bus.i_start) begin
            r_pc      <= '0;
            r_retired <= 16'd0;
            r_busy    <= 1'b1;
            r_halted  <= 1'b0;
            r_state   <= S_FETCH;
          end
        end
        S_FETCH: begin
          if (w_fetch_halt) begin
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else if (w_fetch_ctrl) begin
            r_instrword <= w_fetch;
            r_state     <= S_NEXT;
          end else begin
            r_instrword <= w_fetch;
            r_newinstr  <= 1'b1;
            r_state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_newinstr <= 1'b0;
          r_cnt      <= '0;
          r_state    <= S_EXEC;
        end
        S_EXEC: begin
          if (r_cnt == CNT_W'(EXEC_CYCLES - 1)) begin
            r_state <= S_NEXT;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_NEXT: begin
          r_retired <= w_ret_next;
          if (w_seq_end) begin
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
            r_state  <= S_HALT;
          end else begin
            r_pc    <= w_pc_next;
            r_state <= S_FETCH;
          end
        end
        default: begin
          r_newinstr <= 1'b0;
          r_busy     <= 1'b0;
          r_halted   <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.o_instrword = r_instrword;
  assign bus.o_newinstr  = r_newinstr;
  assign bus.o_pc        = r_pc;
  assign bus.o_busy      = r_busy;
  assign bus.o_halted    = r_halted;
  assign bus.o_retired   = r_retired;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed programs plus random programs, each run
// compared cycle by cycle against an instruction-level timing model.
module tb_instr_fetch_unit;

  localparam int          MAXC  = 300;
  localparam logic [31:0] HALTW = 32'hFFFF_FFFF;
  localparam logic [31:0] W_ADD = 32'h00221820;
  localparam logic [31:0] W_SUB = 32'h00221822;

  logic clk;
  logic rst;

  instr_fetch_unit_if #(.ADDR_W(6)) bus ();

  instr_fetch_unit #(
    .ADDR_W(6), .DEPTH(64), .EXEC_CYCLES(5), .HALT_WORD(32'hFFFF_FFFF)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] tm [64];
  logic [31:0] exp_iw;
  logic [31:0] e_ni [MAXC];
  logic [31:0] e_iw [MAXC];
  logic [31:0] e_pc [MAXC];
  logic [31:0] e_busy [MAXC];
  logic [31:0] e_halt [MAXC];
  logic [31:0] e_ret [MAXC];

  int ni_q [$];
  int first_halt;
  logic [31:0] last_pc, last_ret, last_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic set_k(input int k, input logic [31:0] ni, input logic [31:0] iw,
                       input logic [31:0] pc, input logic [31:0] busy,
                       input logic [31:0] halt, input logic [31:0] ret);
    if (k >= 0 && k < MAXC) begin
      e_ni[k] = ni; e_iw[k] = iw; e_pc[k] = pc;
      e_busy[k] = busy; e_halt[k] = halt; e_ret[k] = ret;
    end
  endtask

  // Instruction-level model: halt word stops after one clock, j/beq cost 2 clocks,
  // anything else costs 8 clocks with the issue pulse in its second clock.
  task automatic build_exp(input logic b);
    int t, pcm, ret, dur, npc, imm;
    bit done, seq;
    logic [31:0] iw, w;
    pcm = 0; ret = 0; t = 0; done = 0; iw = exp_iw;
    set_k(0, 0, iw, 0, 1, 0, 0);
    while (!done && t < MAXC) begin
      w = tm[pcm];
      if (w == HALTW) begin
        for (int k = t + 1; k < MAXC; k++) set_k(k, 0, iw, pcm, 0, 1, ret);
        done = 1;
      end else begin
        iw  = w;
        dur = (w[31:26] == 6'd2 || w[31:26] == 6'd4) ? 2 : 8;
        for (int k = t + 1; k < t + dur; k++)
          set_k(k, (dur == 8 && k == t + 1) ? 1 : 0, iw, pcm, 1, 0, ret);
        if (ret < 65535) ret++;
        imm = int'($signed(w[15:0]));
        seq = 0;
        if (w[31:26] == 6'd2) npc = int'(w[5:0]);
        else if (w[31:26] == 6'd4 && b) npc = (pcm + 1 + imm) & 63;
        else begin npc = pcm + 1; seq = 1; end
        t += dur;
        if (seq && pcm == 63) begin
          for (int k = t; k < MAXC; k++) set_k(k, 0, iw, pcm, 0, 1, ret);
          done = 1;
        end else begin
          pcm = npc;
          set_k(t, 0, iw, pcm, 1, 0, ret);
        end
      end
    end
  endtask

  task automatic load_word(input int a, input logic [31:0] d);
    @(negedge clk);
    bus.i_load_en = 1'b1; bus.i_load_addr = a[5:0]; bus.i_load_data = d;
    tm[a] = d;
    @(negedge clk);
    bus.i_load_en = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_newinstr"}, 32'(bus.o_newinstr), 32'd0);
    chk({tag, "_busy"},     32'(bus.o_busy), 32'd0);
    chk({tag, "_halted"},   32'(bus.o_halted), 32'd0);
    chk({tag, "_pc"},       32'(bus.o_pc), 32'd0);
    chk({tag, "_retired"},  32'(bus.o_retired), 32'd0);
    chk({tag, "_instr"},    bus.o_instrword, 32'd0);
  endtask

  task automatic run_prog(input string name, input int ncyc, input logic b,
                          input bit same_ld, input int sl_addr, input logic [31:0] sl_data,
                          input bit busy_ld, input int rst_k);
    if (same_ld) tm[sl_addr] = sl_data;
    build_exp(b);
    @(negedge clk);
    bus.i_start = 1'b1; bus.i_br_zero = b;
    if (same_ld) begin
      bus.i_load_en = 1'b1; bus.i_load_addr = sl_addr[5:0]; bus.i_load_data = sl_data;
    end
    @(posedge clk);
    ni_q.delete();
    first_halt = -1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (k == 0) begin bus.i_start = 1'b0; bus.i_load_en = 1'b0; end
      chk($sformatf("%s_k%0d_newinstr", name, k), 32'(bus.o_newinstr), e_ni[k]);
      chk($sformatf("%s_k%0d_instr", name, k), bus.o_instrword, e_iw[k]);
      chk($sformatf("%s_k%0d_pc", name, k), 32'(bus.o_pc), e_pc[k]);
      chk($sformatf("%s_k%0d_busy", name, k), 32'(bus.o_busy), e_busy[k]);
      chk($sformatf("%s_k%0d_halted", name, k), 32'(bus.o_halted), e_halt[k]);
      chk($sformatf("%s_k%0d_retired", name, k), 32'(bus.o_retired), e_ret[k]);
      if (bus.o_newinstr === 1'b1) ni_q.push_back(k);
      if (bus.o_halted === 1'b1 && first_halt < 0) first_halt = k;
      last_pc = 32'(bus.o_pc); last_ret = 32'(bus.o_retired); last_halt = 32'(bus.o_halted);
      if (busy_ld && k == 3) begin
        bus.i_load_en = 1'b1; bus.i_load_addr = 6'd1; bus.i_load_data = ~tm[1];
      end
      if (busy_ld && k == 4) bus.i_load_en = 1'b0;
      if (k == rst_k) begin
        #1 rst = 1'b1;
        #1 check_reset_outputs({name, "_midrst"});
        @(negedge clk);
        rst = 1'b0;
        exp_iw = 32'd0;
        return;
      end
    end
    if (e_halt[ncyc-1] == 32'd1) begin
      exp_iw = e_iw[ncyc-1];
    end else begin
      #1 rst = 1'b1;
      #2 rst = 1'b0;
      exp_iw = 32'd0;
    end
  endtask

  function automatic logic [31:0] rand_word();
    int sel, off;
    logic [31:0] w;
    sel = int'($urandom_range(0, 9));
    w   = $urandom;
    off = int'($urandom_range(0, 16)) - 8;
    if (sel < 3)      w[31:26] = 6'h00;
    else if (sel < 5) w[31:26] = 6'h23;
    else if (sel < 7) w[31:26] = 6'd2;
    else if (sel < 9) begin w[31:26] = 6'd4; w[15:0] = off[15:0]; end
    else              w = HALTW;
    return w;
  endfunction

  initial begin
    rst = 1'b0;
    bus.i_start = 1'b0; bus.i_load_en = 1'b0; bus.i_load_addr = 6'd0;
    bus.i_load_data = 32'd0; bus.i_br_zero = 1'b0;
    exp_iw = 32'd0;
    last_pc = 32'd0; last_ret = 32'd0; last_halt = 32'd0;

    // Asynchronous reset mid-cycle clears every output immediately.
    #3 rst = 1'b1;
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    for (int a = 0; a < 64; a++) load_word(a, 32'd0);

    // Straight-line program, with a load attempt while busy.
    load_word(0, W_ADD); load_word(1, W_SUB); load_word(2, HALTW);
    run_prog("straight", 30, 1'b0, 0, 0, 32'd0, 1, -1);
    chk("straight_pulses", 32'(ni_q.size()), 32'd2);
    if (ni_q.size() == 2) chk("straight_gap", 32'(ni_q[1] - ni_q[0]), 32'd8);
    chk("straight_pc", last_pc, 32'd2);
    chk("straight_ret", last_ret, 32'd2);
    chk("straight_halt", last_halt, 32'd1);

    // Reset while newinstr is high, then while executing; reruns must match.
    run_prog("rst_issue", 30, 1'b0, 0, 0, 32'd0, 0, 1);
    run_prog("rerun1", 30, 1'b0, 0, 0, 32'd0, 0, -1);
    chk("rerun1_pulses", 32'(ni_q.size()), 32'd2);
    run_prog("rst_exec", 30, 1'b0, 0, 0, 32'd0, 0, 5);
    run_prog("rerun2", 30, 1'b0, 0, 0, 32'd0, 0, -1);
    chk("rerun2_ret", last_ret, 32'd2);

    // Load in the same cycle as start must be fetched.
    run_prog("same_ld", 30, 1'b0, 1, 0, W_SUB, 0, -1);
    chk("same_ld_pulses", 32'(ni_q.size()), 32'd2);

    // Jump.
    load_word(0, 32'h08000005); load_word(5, HALTW);
    run_prog("jump", 12, 1'b0, 0, 0, 32'd0, 0, -1);
    chk("jump_pulses", 32'(ni_q.size()), 32'd0);
    chk("jump_pc", last_pc, 32'd5);
    chk("jump_ret", last_ret, 32'd1);
    chk("jump_halt_k", 32'(first_halt), 32'd3);

    // Branch taken / not taken / self-loop.
    load_word(0, 32'h10220003); load_word(1, HALTW); load_word(4, HALTW);
    run_prog("beq_t", 12, 1'b1, 0, 0, 32'd0, 0, -1);
    chk("beq_t_pc", last_pc, 32'd4);
    run_prog("beq_nt", 12, 1'b0, 0, 0, 32'd0, 0, -1);
    chk("beq_nt_pc", last_pc, 32'd1);
    load_word(0, 32'h1022FFFF);
    run_prog("beq_loop", 30, 1'b1, 0, 0, 32'd0, 0, -1);
    chk("beq_loop_pc", last_pc, 32'd0);
    chk("beq_loop_halt", last_halt, 32'd0);

    // End of memory: sequential step from the last word halts.
    load_word(0, 32'h0800003F); load_word(63, W_ADD);
    run_prog("endmem", 20, 1'b0, 0, 0, 32'd0, 0, -1);
    chk("endmem_pulses", 32'(ni_q.size()), 32'd1);
    chk("endmem_pc", last_pc, 32'd63);
    chk("endmem_ret", last_ret, 32'd2);
    chk("endmem_halt", last_halt, 32'd1);

    // Random programs against the model.
    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < 64; a++) load_word(a, rand_word());
      run_prog($sformatf("rand%0d", r), 250, 1'($urandom_range(0, 1)), 0, 0, 32'd0, 0, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction-issue front end for `mipscpu`. It holds the program counter and a loadable instruction memory. It drives `instrword` and the single-cycle `newinstr` pulse into the multi-cycle datapath, then waits for that instruction's execution window to close. It resolves `j` and `beq` internally and stops on a halt word.

## Interface
- `ADDR_W`, 6: PC / instruction-memory address width, in words.
- `DEPTH`, 2**`ADDR_W`: instruction-memory depth.
- `EXEC_CYCLES`, 5: clocks the datapath needs after `newinstr` before the next issue. The datapath FSM writes back on its 5th clock.
- `HALT_WORD`, 32'hFFFF_FFFF: encoding that stops execution.
- `clk`, in, 1: clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: begin execution at PC 0; sampled only in IDLE or HALT.
- `load_en`, in, 1: instruction-memory write strobe; honoured only in IDLE or HALT.
- `load_addr`, in, `ADDR_W`: write address.
- `load_data`, in, 32: write data.
- `br_zero`, in, 1: external comparator result, rs == rt, for the current `instrword`; sampled in NEXT.
- `instrword`, out, 32: current instruction to the datapath; registered.
- `newinstr`, out, 1: one-clock issue pulse; registered.
- `pc`, out, `ADDR_W`: address of the current instruction.
- `busy`, out, 1: high in FETCH, ISSUE, EXEC and NEXT.
- `halted`, out, 1: high in HALT.
- `retired`, out, 16: instructions completed since the last start; saturates at 16'hFFFF.

## Operation
- **States:** IDLE, FETCH, ISSUE, EXEC, NEXT, HALT.
- **IDLE:** `start` sets `pc` to 0, clears `retired`, and moves to FETCH.
- **FETCH:** reads `mem[pc]` as W.
  - W == `HALT_WORD`: go to HALT; `instrword` is unchanged.
  - Opcode W[31:26] == 2 (`j`) or 4 (`beq`): `instrword` <= W, `newinstr` stays 0, go to NEXT.
  - Otherwise: `instrword` <= W, `newinstr` <= 1, go to ISSUE.
- **ISSUE:** lasts one cycle; `newinstr` <= 0, clear the cycle counter, go to EXEC.
- **EXEC:** counts `EXEC_CYCLES` cycles, then goes to NEXT.
- **NEXT:** increments `retired` (saturating) and computes the next PC.
  - `j`: `pc` <= W[`ADDR_W`-1:0]; the target wraps modulo `DEPTH`.
  - `beq` with `br_zero` = 1: `pc` <= `pc` + 1 + sign-extended W[15:0], truncated to `ADDR_W` bits (modulo wrap).
  - `beq` with `br_zero` = 0, and all other instructions: `pc` <= `pc` + 1.
  - A sequential step from `pc` == `DEPTH`-1 does not wrap: go to HALT with `pc` held at `DEPTH`-1. Otherwise go to FETCH.
- **HALT:** `halted` = 1. `start` restarts exactly as from IDLE.
- **Load port:** in IDLE or HALT, `load_en` writes `mem[load_addr]` <= `load_data` at the clock edge.
  - If `load_en` and `start` occur in the same cycle, the write lands before the first FETCH reads it.
  - `load_en` while `busy` is ignored.
- **Reset values:** state IDLE; `instrword`, `newinstr`, `pc`, `busy`, `halted`, `retired` all 0.
- **Reset mid-operation:** asynchronous; `newinstr` drops immediately and the cycle counter clears. Instruction memory is not reset; its contents are retained.

## Timing
- `start` is sampled at edge E0; FETCH occupies E0..E1.
- At E1, `instrword` and `newinstr` = 1 update together. `newinstr` is high for exactly one clock.
- **ALU / lw / sw issue period:** 1 (FETCH) + 1 (ISSUE) + `EXEC_CYCLES` + 1 (NEXT) = `EXEC_CYCLES`+3 clocks. With defaults, consecutive `newinstr` rises are 8 clocks apart.
- **Control-flow instructions:** `j` and `beq` take 2 clocks (FETCH, NEXT) and produce no `newinstr`. `br_zero` must be valid by the clock after `instrword` changes.
- **Halt:** FETCH of `HALT_WORD` gives `halted` = 1 one clock later; `busy` = 0 in the same cycle.
- `retired` and `pc` update at the NEXT-exit edge.

## Test plan
- **Reset:** assert `rst` mid-cycle -> all outputs 0 immediately; state IDLE.
- **Straight-line program:** load mem[0]=32'h00221820 (add), mem[1]=32'h00221822 (sub), mem[2]=`HALT_WORD`; pulse `start`.
  - Required: two `newinstr` pulses 8 clocks apart, with `instrword` 32'h00221820 then 32'h00221822.
  - End state: `halted` = 1, `pc` = 2, `retired` = 2.
- **Jump:** mem[0]=32'h08000005, mem[5]=`HALT_WORD`; start.
  - Required: no `newinstr` at all; `pc` = 5, `retired` = 1, `halted` asserted 3 clocks after FETCH at PC 0.
- **Branch:** mem[0]=32'h10220003 (beq, imm 3).
  - `br_zero` = 1 -> next fetch at `pc` = 4.
  - `br_zero` = 0 -> next fetch at `pc` = 1.
  - Imm 16'hFFFF with `br_zero` = 1 -> `pc` = 0, loops back to itself.
- **End of memory:** mem[0]=32'h0800003F, mem[63]=add; start -> one `newinstr` at `pc` = 63, then HALT with `pc` = 63 and `retired` = 2.
- **Busy protection and mid-run reset:** during EXEC, drive `load_en` to mem[1] -> memory unchanged.
  - Assert `rst` during EXEC -> `newinstr` = 0, `busy` = 0, memory preserved.
  - `start` after reset re-runs the original program identically.
